// File: rtl/router_node_port.sv
// Router-side endpoint of the byte-serial node link: reassembles 4-byte
// node packets into an ingress FIFO and serialises crossbar packets to the node.
//
// Ports:
//   clock, reset_n           clock, async active-low reset
//   free_outbound            port can take a new node packet next cycle
//   put_outbound             node strobe, byte0 present on payload_outbound
//   payload_outbound[7:0]    byte from node
//   free_inbound             node can accept a new packet
//   put_inbound              strobe to node, byte0 present (registered)
//   payload_inbound[7:0]     byte to node (registered)
//   in_pkt[31:0]             ingress FIFO head word (0 when empty)
//   in_pkt_valid             ingress FIFO non-empty
//   in_pkt_ready             crossbar pops in_pkt this cycle
//   out_pkt[31:0]            packet from crossbar
//   out_pkt_valid            out_pkt valid
//   out_pkt_ready            port accepts out_pkt this cycle
//   proto_err                sticky link protocol error (only with
//                            ROUTER_PORT_PROTO_CHK_EN defined)
//
// Optional feature macro: ROUTER_PORT_PROTO_CHK_EN
module router_node_port #(
  parameter int NODEID = 0,
  parameter int DEPTH  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        free_outbound,
  input  logic        put_outbound,
  input  logic [7:0]  payload_outbound,
  input  logic        free_inbound,
  output logic        put_inbound,
  output logic [7:0]  payload_inbound,
  output logic [31:0] in_pkt,
  output logic        in_pkt_valid,
  input  logic        in_pkt_ready,
  input  logic [31:0] out_pkt,
  input  logic        out_pkt_valid,
  output logic        out_pkt_ready
`ifdef ROUTER_PORT_PROTO_CHK_EN
  ,
  output logic        proto_err
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    R_IDLE,
    R_B1,
    R_B2,
    R_B3
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_B0,
    T_B1,
    T_B2,
    T_B3
  } tx_state_t;

  // ---------------- RX path ----------------

  rx_state_t   rx_state;
  logic [23:0] rx_acc;
  logic        rx_busy;
  logic        rx_start;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          push;
  logic          pop;

  assign rx_busy = (rx_state != R_IDLE);

  // The packet in flight reserves a slot; pops are credited next cycle.
  assign occ = {1'b0, count} + {{CW{1'b0}}, rx_busy};
  assign free_outbound = (occ < (CW + 1)'(DEPTH));

  assign rx_start = put_outbound && free_outbound && !rx_busy;
  assign push     = (rx_state == R_B3);
  assign pop      = in_pkt_valid && in_pkt_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= R_IDLE;
      rx_acc   <= '0;
    end else begin
      unique case (rx_state)
        R_IDLE: begin
          if (rx_start) begin
            rx_acc[23:16] <= payload_outbound;
            rx_state      <= R_B1;
          end
        end
        R_B1: begin
          rx_acc[15:8] <= payload_outbound;
          rx_state     <= R_B2;
        end
        R_B2: begin
          rx_acc[7:0] <= payload_outbound;
          rx_state    <= R_B3;
        end
        R_B3: begin
          rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Storage is not reset: count gates visibility of every word.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {rx_acc, payload_outbound};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign in_pkt_valid = (count != '0);
  assign in_pkt       = in_pkt_valid ? mem[rd_ptr] : 32'h0;

`ifdef ROUTER_PORT_PROTO_CHK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if (put_outbound && (rx_busy || !free_outbound)) begin
      proto_err <= 1'b1;
    end
  end
`endif

  // ---------------- TX path ----------------

  tx_state_t   tx_state;
  logic [23:0] tx_data;

  assign out_pkt_ready = (tx_state == T_IDLE) && free_inbound;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state        <= T_IDLE;
      tx_data         <= '0;
      put_inbound     <= 1'b0;
      payload_inbound <= '0;
    end else begin
      unique case (tx_state)
        T_IDLE: begin
          put_inbound     <= 1'b0;
          payload_inbound <= '0;
          if (out_pkt_valid && out_pkt_ready) begin
            tx_data         <= out_pkt[23:0];
            put_inbound     <= 1'b1;
            payload_inbound <= out_pkt[31:24];
            tx_state        <= T_B0;
          end
        end
        T_B0: begin
          put_inbound     <= 1'b0;
          payload_inbound <= tx_data[23:16];
          tx_state        <= T_B1;
        end
        T_B1: begin
          payload_inbound <= tx_data[15:8];
          tx_state        <= T_B2;
        end
        T_B2: begin
          payload_inbound <= tx_data[7:0];
          tx_state        <= T_B3;
        end
        T_B3: begin
          payload_inbound <= '0;
          tx_state        <= T_IDLE;
        end
        default: begin
          put_inbound     <= 1'b0;
          payload_inbound <= '0;
          tx_state        <= T_IDLE;
        end
      endcase
    end
  end

  // ---------------- checks ----------------

  a_no_overflow: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(push && !pop && (count == CW'(DEPTH)))
  ) else $error("router_node_port node %0d: ingress overflow", NODEID);

  a_tx_hold_ready: assert property (
    @(posedge clock) disable iff (!reset_n)
    (tx_state != T_IDLE) |-> !out_pkt_ready
  ) else $error("router_node_port node %0d: ready while busy", NODEID);

endmodule

// File: doc/router_node_port.md
Name: router_node_port

Overview:
- Router-side endpoint of the node/router byte-serial link; one instance per router port that faces a node.
- Accepts the 4-byte stream a node sends (free_outbound/put_outbound/payload_outbound), reassembles it into a pkt_t and buffers it for the crossbar.
- Takes pkt_t from the crossbar and streams it to the node as 4 bytes (free_inbound/put_inbound/payload_inbound).
- Wire format: byte0={src,dest}, byte1=data[23:16], byte2=data[15:8], byte3=data[7:0]. put is a 1-cycle strobe on byte0 only; bytes 1-3 follow on consecutive cycles.

Parameters:
NODEID, 0, id of the attached node (informational; used in assertion messages only)
DEPTH, 2, ingress packet buffer depth in packets (>=1)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
free_outbound  output  1  port can accept a new packet starting next cycle
put_outbound  input  1  node strobe, byte0 present
payload_outbound  input  8  byte from node
free_inbound  input  1  node can accept a new packet
put_inbound  output  1  strobe to node, byte0 present
payload_inbound  output  8  byte to node
in_pkt  output  32  pkt_t at ingress buffer head, to crossbar
in_pkt_valid  output  1  ingress buffer non-empty
in_pkt_ready  input  1  crossbar consumes in_pkt this cycle
out_pkt  input  32  pkt_t from crossbar for this node
out_pkt_valid  input  1  out_pkt valid
out_pkt_ready  output  1  port accepts out_pkt this cycle

Behaviour:
- Reset (async, any state): RX/TX FSMs to IDLE, buffer empty, partial packets discarded. Outputs: put_inbound=0, payload_inbound=0, in_pkt=0, in_pkt_valid=0, free_outbound=1, out_pkt_ready=free_inbound.
- RX FSM: R_IDLE, R_B1, R_B2, R_B3.
  - In R_IDLE, if put_outbound && free_outbound: capture payload into [31:24] and go to R_B1.
  - R_B1 captures [23:16], R_B2 captures [15:8].
  - R_B3 captures [7:0], writes the word into the ingress FIFO on that edge, and returns to R_IDLE.
  - put_outbound outside R_IDLE, or while free_outbound=0, is ignored.
- free_outbound (combinational) = (count + (rx_state!=R_IDLE)) < DEPTH. Pops are not credited in the same cycle. This is high in the byte3 cycle if one slot remains after the current packet, so back-to-back node packets are accepted with no gap.
- Ingress FIFO:
  - Circular buffer; pointers wrap DEPTH-1 -> 0.
  - in_pkt = head word, or 0 when empty. in_pkt_valid = count!=0.
  - Pop on in_pkt_valid && in_pkt_ready.
  - Simultaneous push and pop leaves count unchanged; push when full cannot occur by construction.
  - Latency: byte3 edge -> in_pkt_valid=1 the following cycle.
- TX FSM: T_IDLE, T_B0, T_B1, T_B2, T_B3. All byte outputs are registered.
  - out_pkt_ready (combinational) = (tx_state==T_IDLE) && free_inbound.
  - On out_pkt_valid && out_pkt_ready: latch out_pkt and go to T_B0.
  - T_B0: put_inbound=1, payload_inbound={src,dest}.
  - T_B1/T_B2/T_B3: put_inbound=0, payload = [23:16] / [15:8] / [7:0].
  - Then return to T_IDLE; payload_inbound=0 in T_IDLE.
  - Minimum one T_IDLE cycle between outbound packets.
- RX and TX paths are fully independent; both may be active every cycle.

Optional Feature:
ROUTER_PORT_PROTO_CHK_EN
- Defined: adds output proto_err (1 bit, reset 0, sticky until reset). It is set on the edge after either:
  - put_outbound=1 while rx_state!=R_IDLE, or
  - put_outbound=1 while free_outbound=0.
  The offending strobe is still ignored.
- Undefined: proto_err port and logic are absent; violations are silently ignored.

Test Plan:
- Reset, then node sends put on byte0=0x37 followed by 0xAB,0xCD,0xEF with in_pkt_ready=0 -> in_pkt=0x37ABCDEF, in_pkt_valid=1 the cycle after 0xEF.
- DEPTH=2, in_pkt_ready=0: two back-to-back node packets -> free_outbound=1 during the first packet's byte3 cycle; after the second packet free_outbound=0 and a third put is ignored. Raise in_pkt_ready -> both pop in order, then free_outbound=1.
- out_pkt=0x5A123456, out_pkt_valid=1, free_inbound=1 -> over the next 4 cycles put_inbound=1,0,0,0 and payload=0x5A,0x12,0x34,0x56.
- free_inbound=0 with out_pkt_valid=1 -> out_pkt_ready=0 and nothing is sent. Raise free_inbound -> transfer starts the next cycle.
- reset_n pulsed low during RX byte2 and TX byte1 -> partial packets discarded, in_pkt_valid=0, put_inbound=0. A fresh packet after reset is received correctly.
- With ROUTER_PORT_PROTO_CHK_EN: put_outbound=1 during R_B2 -> proto_err=1 next cycle and stays 1; the in-progress packet is unaffected.
